// File: rtl/ballot_arbiter.sv
// ballot_arbiter: round-robin arbiter that grants one voting booth at a time and forwards its vote to the tally.
// Define BALLOT_ARBITER_AUDIT_EN to enable the saturating accepted-vote counter on audit_count.
//
// state    | meaning
// ST_IDLE  | no session open; arbitrate among requesting booths
// ST_WAIT  | booth r_idx granted; waiting for a non-zero cast, abort or timeout
// ST_ISSUE | latched vote offered to the tally; waiting for vote_ready
module ballot_arbiter #(
  parameter int N_BOOTH = 4,
  parameter int CAND_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [N_BOOTH-1:0]          booth_req,
  input  logic [N_BOOTH-1:0]          booth_cast,
  input  logic [N_BOOTH*CAND_W-1:0]   booth_cand,
  output logic [N_BOOTH-1:0]          booth_grant,
  output logic [N_BOOTH-1:0]          booth_ack,
  output logic                        vote_valid,
  output logic [CAND_W-1:0]           vote_cand,
  input  logic                        vote_ready,
  output logic                        timeout_err,
  output logic                        busy,
  output logic [15:0]                 audit_count
);

  localparam int PTR_W = $clog2(N_BOOTH);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_t;

  state_t             r_state, w_state;
  logic [PTR_W-1:0]   r_ptr, w_ptr;
  logic [PTR_W-1:0]   r_idx, w_idx;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic [N_BOOTH-1:0] r_grant, w_grant;
  logic [N_BOOTH-1:0] r_ack, w_ack;
  logic               r_valid, w_valid;
  logic               r_tout, w_tout;
  logic [CAND_W-1:0]  r_cand, w_cand;

  logic [CAND_W-1:0]  w_cands [N_BOOTH];
  logic [PTR_W-1:0]   w_try, w_sel;
  logic               w_found;

  for (genvar g = 0; g < N_BOOTH; g++) begin : g_cand
    assign w_cands[g] = booth_cand[g*CAND_W +: CAND_W];
  end

  // Round-robin search: first requester strictly after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_try   = r_ptr;
    for (int i = 0; i < N_BOOTH; i++) begin
      w_try = (w_try == PTR_W'(N_BOOTH-1)) ? '0 : w_try + PTR_W'(1);
      if (!w_found && booth_req[w_try]) begin
        w_found = 1'b1;
        w_sel   = w_try;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_timer = r_timer;
    w_grant = r_grant;
    w_ack   = '0;
    w_valid = r_valid;
    w_cand  = r_cand;
    w_tout  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && w_found) begin
          w_idx   = w_sel;
          w_grant = N_BOOTH'(1) << w_sel;
          w_timer = '0;
          w_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable || !booth_req[r_idx]) begin
          w_grant = '0;
          w_ptr   = r_idx;
          w_state = ST_IDLE;
        end else if (booth_cast[r_idx] && (w_cands[r_idx] != '0)) begin
          w_cand  = w_cands[r_idx];
          w_grant = '0;
          w_valid = 1'b1;
          w_state = ST_ISSUE;
        end else if (r_timer == TMR_W'(TIMEOUT-1)) begin
          w_grant = '0;
          w_tout  = 1'b1;
          w_ptr   = r_idx;
          w_state = ST_IDLE;
        end else begin
          w_timer = r_timer + TMR_W'(1);
        end
      end
      ST_ISSUE: begin
        // enable is deliberately ignored: an offered vote always completes.
        if (vote_ready) begin
          w_ack   = N_BOOTH'(1) << r_idx;
          w_valid = 1'b0;
          w_ptr   = r_idx;
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_W'(N_BOOTH-1);
      r_idx   <= '0;
      r_timer <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_cand  <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_timer <= w_timer;
      r_grant <= w_grant;
      r_ack   <= w_ack;
      r_valid <= w_valid;
      r_cand  <= w_cand;
      r_tout  <= w_tout;
    end
  end

  assign booth_grant = r_grant;
  assign booth_ack   = r_ack;
  assign vote_valid  = r_valid;
  assign vote_cand   = r_cand;
  assign timeout_err = r_tout;
  assign busy        = (r_state != ST_IDLE);

`ifdef BALLOT_ARBITER_AUDIT_EN
  logic [15:0] r_audit;
  logic        w_hs;

  assign w_hs = (r_state == ST_ISSUE) && vote_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_audit <= '0;
    end else if (w_hs && (r_audit != 16'hFFFF)) begin
      r_audit <= r_audit + 16'd1;
    end
  end

  assign audit_count = r_audit;
`else
  assign audit_count = 16'h0000;
`endif

endmodule

// File: doc/ballot_arbiter.md
# ballot_arbiter

Shares the single vote-tally datapath among several voting booths. Booths raise a request. The arbiter grants one booth at a time in round-robin order and waits for that booth to cast a valid candidate code. It then forwards the vote to the tally over a valid/ready handshake and acknowledges the booth. It sits between the booth front-ends and the tally/result engine. It also enforces a per-session timeout so that an abandoned booth cannot stall the poll.

## Interface

Parameters:
- N_BOOTH, 4, number of requesting booths (2..8)
- CAND_W, 4, candidate code width; code 0 is "no selection" and invalid
- TIMEOUT, 255, maximum cycles a grant is held waiting for a cast (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  poll open; low blocks new grants and aborts an open session
- booth_req  in  N_BOOTH  per-booth session request, level
- booth_cast  in  N_BOOTH  per-booth cast strobe, level
- booth_cand  in  N_BOOTH*CAND_W  per-booth candidate code; booth k occupies bits [k*CAND_W +: CAND_W]
- booth_grant  out  N_BOOTH  one-hot grant, registered
- booth_ack  out  N_BOOTH  one-cycle pulse: the vote was accepted by the tally
- vote_valid  out  1  vote offered to the tally
- vote_cand  out  CAND_W  candidate code of the offered vote
- vote_ready  in  1  tally accepts the vote when high together with vote_valid
- timeout_err  out  1  one-cycle pulse: the session expired without a vote
- busy  out  1  high in WAIT or ISSUE
- audit_count  out  16  accepted-vote count (see Configuration)

## Operation

- Reset values: booth_grant=0, booth_ack=0, vote_valid=0, vote_cand=0, timeout_err=0, busy=0, audit_count=0, state=IDLE.
- The round-robin pointer ptr resets to N_BOOTH-1, so booth 0 has first priority.
- IDLE:
  - Condition: enable=1 and booth_req≠0.
  - Select the first requesting booth searching from ptr+1, wrapping modulo N_BOOTH.
  - Assert its booth_grant, clear the timer and go to WAIT.
- WAIT: booth_grant[k] is held. Conditions are evaluated in this priority order:
  1. enable=0 or booth_req[k]=0: abort. Go to IDLE with no vote, no ack and no timeout_err. ptr is set to k.
  2. booth_cast[k]=1 and booth_cand[k]≠0: latch the code into vote_cand, drop the grant and go to ISSUE.
  3. The timer equals TIMEOUT-1: pulse timeout_err and go to IDLE. ptr is set to k.
  4. Otherwise increment the timer.
- A cast with code 0 is ignored; the timer keeps running.
- Casts, codes and requests from non-granted booths are ignored.
- ISSUE:
  - vote_valid=1, and vote_cand is held stable until vote_ready=1.
  - At the handshake edge: pulse booth_ack[k], clear vote_valid, set ptr=k and go to IDLE.
  - enable dropping during ISSUE does not cancel the vote. An in-flight vote always completes.
- Timer width is $clog2(TIMEOUT). The timer never wraps because it is bounded by TIMEOUT-1.

## Timing

- booth_req is sampled at edge E0 while in IDLE; booth_grant is high from E0.
- If the cast is sampled at edge Ec, the grant drops and vote_valid rises from Ec.
- If vote_valid and vote_ready are both high at edge Eh, booth_ack is high for exactly the cycle after Eh.
- booth_ack is coincident with IDLE. Arbitration in that cycle can produce the next grant at the following edge, so the minimum gap between grants is 1 idle cycle.
- In the worst case, the grant is held exactly TIMEOUT cycles. timeout_err is high during the first IDLE cycle after expiry.
- vote_valid has no combinational dependence on vote_ready. No output is combinational from any input.
- Asserting rst_n low in any state forces all reset values immediately. A pending vote is discarded and no ack is issued.

## Configuration

- BALLOT_ARBITER_AUDIT_EN defined:
  - audit_count increments on every tally handshake.
  - It saturates at 16'hFFFF and never wraps.
  - It is cleared only by rst_n.
- BALLOT_ARBITER_AUDIT_EN undefined: audit_count is tied to 0, no counter logic is present, and the port list is unchanged.

## Test plan

- Conditions: N_BOOTH=4, CAND_W=4, TIMEOUT=8 unless stated otherwise.
- Reset release, enable=1, booth_req=4'b0101, vote_ready=1:
  - booth_grant=4'b0001 first. Booth 0 casts cand 3, giving vote_valid=1 with vote_cand=3, then booth_ack=4'b0001.
  - The next grant is 4'b0100.
- Fairness: all four requests held with casts immediate. The grant sequence is 0,1,2,3,0 and no booth is granted twice before all the others.
- Timeout: granted booth casts cand 0 continuously. Grant is held 8 cycles, then a single timeout_err pulse; vote_valid stays 0 and booth_ack stays 0.
- Backpressure: vote_ready held low for 5 cycles after a cast of cand 9.
  - vote_valid=1 and vote_cand=9 are stable for all 5 cycles.
  - booth_ack pulses once, the cycle after vote_ready rises.
- Reset mid-ISSUE: rst_n pulled low while vote_valid=1. All outputs are 0 immediately and no ack is issued. After release, booth 0 has priority again.
- Audit: three accepted votes give audit_count=3 with BALLOT_ARBITER_AUDIT_EN defined, and 0 without it. An aborted or timed-out session does not increment the count.
